// File: rtl/multiplier_fp_param.sv
// ---------------------------------------------------------------------------
// multiplier_fp_param
//
// Multi-cycle floating-point multiplier for a parameterised IEEE-style
// format {sign, exponent[EXP_W], fraction[MAN_W]}. Operands are captured on
// start, classified, and then either resolved immediately (NaN, infinity,
// zero) or multiplied by a shift-add significand multiplier. This is
// followed by a one-step normalise and a rounding stage. Subnormal inputs
// are flushed to signed zero, and results that underflow are also flushed
// to signed zero.
//
// Configuration macro:
//   MULT_FP_RNE_EN  defined   -> round-to-nearest, ties-to-even
//                   undefined -> truncation toward zero (default)
//   The latency is the same in both modes.
//
// Ports:
//   clk    in   1  clock, all state changes on the rising edge
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  multiply request, accepted only in IDLE or DONE
//   A      in   W  first operand
//   B      in   W  second operand
//   Y      out  W  registered product, updated only on entry to DONE
//   busy   out  1  high in UNPACK, MULT, NORM and ROUND
//   ready  out  1  one-cycle pulse (DONE state) marking Y valid
// ---------------------------------------------------------------------------
module multiplier_fp_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [EXP_W+MAN_W:0] A,
    input  logic [EXP_W+MAN_W:0] B,
    output logic [EXP_W+MAN_W:0] Y,
    output logic                 busy,
    output logic                 ready
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int N    = MAN_W + 1;
    localparam int PW   = 2 * N;
    localparam int CW   = $clog2(N + 1);
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic [CW-1:0]          CNT_LAST  = CW'(N - 1);
    localparam logic signed [EXP_W+1:0] BIAS_X    = (EXP_W+2)'(BIAS);
    localparam logic signed [EXP_W+1:0] EXP_SAT_X = (EXP_W+2)'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        MULT,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_nextState;

    logic [W-1:0]             r_a;
    logic [W-1:0]             r_b;
    logic [W-1:0]             r_y;
    logic [PW-1:0]            r_mcand;
    logic [N-1:0]             r_mplr;
    logic [PW-1:0]            r_acc;
    logic [CW-1:0]            r_cnt;
    logic signed [EXP_W+1:0]  r_exp;
`ifdef MULT_FP_RNE_EN
    logic                     r_sticky;
`endif

    // Operand fields and classification, taken from the captured operands.
    logic                     w_signA;
    logic                     w_signB;
    logic [EXP_W-1:0]         w_expA;
    logic [EXP_W-1:0]         w_expB;
    logic [MAN_W-1:0]         w_fracA;
    logic [MAN_W-1:0]         w_fracB;
    logic                     w_zeroA;
    logic                     w_zeroB;
    logic                     w_infA;
    logic                     w_infB;
    logic                     w_nanA;
    logic                     w_nanB;
    logic                     w_sign;
    logic                     w_resNan;
    logic                     w_resInf;
    logic                     w_special;
    logic [W-1:0]             w_specialY;

    logic signed [EXP_W+1:0]  w_expSum;
    logic                     w_normShift;

    logic [MAN_W-1:0]         w_frac;
    logic                     w_roundUp;
    logic [MAN_W:0]           w_fracRnd;
    logic signed [EXP_W+1:0]  w_expFinal;
    logic [W-1:0]             w_roundY;
`ifdef MULT_FP_RNE_EN
    logic                     w_guard;
    logic                     w_stickyAll;
`endif

    assign w_signA = r_a[W-1];
    assign w_signB = r_b[W-1];
    assign w_expA  = r_a[W-2:MAN_W];
    assign w_expB  = r_b[W-2:MAN_W];
    assign w_fracA = r_a[MAN_W-1:0];
    assign w_fracB = r_b[MAN_W-1:0];

    // An exponent field of zero covers both true zero and subnormals,
    // which are flushed to zero.
    assign w_zeroA = ~|w_expA;
    assign w_zeroB = ~|w_expB;
    assign w_infA  = (&w_expA) & ~(|w_fracA);
    assign w_infB  = (&w_expB) & ~(|w_fracB);
    assign w_nanA  = (&w_expA) & (|w_fracA);
    assign w_nanB  = (&w_expB) & (|w_fracB);

    assign w_sign    = w_signA ^ w_signB;
    assign w_resNan  = w_nanA | w_nanB | (w_infA & w_zeroB) | (w_infB & w_zeroA);
    assign w_resInf  = w_infA | w_infB;
    assign w_special = w_resNan | w_resInf | w_zeroA | w_zeroB;

    // Result for operands that never need the multiplier. After NaN and
    // infinity are ruled out, the remaining special case is a zero operand.
    always_comb begin
        w_specialY = {w_sign, {(W-1){1'b0}}};
        if (w_resNan) begin
            w_specialY = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (w_resInf) begin
            w_specialY = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    // The biased exponent sum is held with two extra bits so that both
    // overflow above the all-ones code and underflow below zero are visible.
    assign w_expSum    = $signed({2'b00, w_expA}) + $signed({2'b00, w_expB}) - BIAS_X;
    assign w_normShift = r_acc[PW-1];

    // After normalisation the hidden one sits at bit PW-2. The stored
    // fraction is the MAN_W bits below it, and everything lower is
    // available for rounding.
    assign w_frac = r_acc[PW-3 -: MAN_W];

`ifdef MULT_FP_RNE_EN
    assign w_guard     = r_acc[MAN_W-1];
    assign w_stickyAll = (|r_acc[MAN_W-2:0]) | r_sticky;
    assign w_roundUp   = w_guard & (w_stickyAll | w_frac[0]);
`else
    assign w_roundUp   = 1'b0;
`endif

    // A carry out of the rounded fraction means the significand reached
    // 2.0. The low fraction bits are already zero in that case, so
    // renormalising only needs the exponent bump.
    assign w_fracRnd  = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_roundUp};
    assign w_expFinal = r_exp + $signed({{(EXP_W+1){1'b0}}, w_fracRnd[MAN_W]});

    // Pack the rounded result, saturating to infinity or flushing to zero
    // when the exponent falls outside the normal range.
    always_comb begin
        w_roundY = {w_sign, w_expFinal[EXP_W-1:0], w_fracRnd[MAN_W-1:0]};
        if (w_expFinal >= EXP_SAT_X) begin
            w_roundY = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_expFinal[EXP_W+1] || (w_expFinal == '0)) begin
            w_roundY = {w_sign, {(W-1){1'b0}}};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and status decode. DONE behaves like IDLE for start, so
    // back-to-back requests lose no cycle.
    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        ready       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = UNPACK;
                end
            end
            UNPACK: begin
                busy        = 1'b1;
                w_nextState = w_special ? DONE : MULT;
            end
            MULT: begin
                busy = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_nextState = NORM;
                end
            end
            NORM: begin
                busy        = 1'b1;
                w_nextState = ROUND;
            end
            ROUND: begin
                busy        = 1'b1;
                w_nextState = DONE;
            end
            DONE: begin
                ready       = 1'b1;
                w_nextState = start ? UNPACK : IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath. Operands are captured only when a request is accepted. The
    // multiplier retires one multiplier bit per cycle, starting at the LSB,
    // with the multiplicand shifted left alongside it. Y is written only on
    // the transitions into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_y      <= '0;
            r_mcand  <= '0;
            r_mplr   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_exp    <= '0;
`ifdef MULT_FP_RNE_EN
            r_sticky <= 1'b0;
`endif
        end else begin
            if (((r_state == IDLE) || (r_state == DONE)) && start) begin
                r_a <= A;
                r_b <= B;
            end
            case (r_state)
                UNPACK: begin
                    if (w_special) begin
                        r_y <= w_specialY;
                    end else begin
                        r_mcand <= {{N{1'b0}}, 1'b1, w_fracA};
                        r_mplr  <= {1'b1, w_fracB};
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                MULT: begin
                    if (r_mplr[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= r_mplr >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                end
                NORM: begin
                    r_exp <= w_expSum + $signed({{(EXP_W+1){1'b0}}, w_normShift});
                    if (w_normShift) begin
                        r_acc <= r_acc >> 1;
                    end
`ifdef MULT_FP_RNE_EN
                    r_sticky <= w_normShift & r_acc[0];
`endif
                end
                ROUND: begin
                    r_y <= w_roundY;
                end
                default: begin
                end
            endcase
        end
    end

    assign Y = r_y;

endmodule

// File: tb/tb_multiplier_fp_param.sv
// ---------------------------------------------------------------------------
// tb_multiplier_fp_param
//
// Directed-vector bench for multiplier_fp_param at default parameters.
// The stimulus process pushes each expected product, together with its
// expected latency and the accept cycle, into a queue. A monitor process
// pops that queue on every ready pulse and checks Y, the latency and the
// length of the busy run before ready. On every other cycle the monitor
// checks that Y still holds the last delivered result.
// ---------------------------------------------------------------------------
module tb_multiplier_fp_param;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int W        = 1 + EXP_W + MAN_W;
    localparam int NORM_LAT = 28;
    localparam int SPEC_LAT = 2;

    typedef struct {
        logic [W-1:0] y;
        int           lat;
        int           acceptCycle;
        int           tag;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Y;
    logic         busy;
    logic         ready;

    exp_t         sbq[$];
    exp_t         cur;
    int           total      = 0;
    int           bad        = 0;
    int           cycleCount = 0;
    int           busyRun    = 0;
    int           measLat    = 0;
    logic [W-1:0] lastY      = '0;
    logic [W-1:0] rneExp;

    multiplier_fp_param #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .A    (A),
        .B    (B),
        .Y    (Y),
        .busy (busy),
        .ready(ready)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to time each operation from its accept edge.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Compare one value and count the result.
    task automatic checkOutput(input string what, input logic [W-1:0] actual,
                               input logic [W-1:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%h required=0x%h", what, actual, required);
        end
    endtask

    // Wait n cycles, then return 2 time units after the last rising edge.
    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Record an expected product for an operation accepted on the last edge.
    task automatic pushExpected(input logic [W-1:0] expY, input int expLat, input int tag);
        exp_t e;
        e.y           = expY;
        e.lat         = expLat;
        e.acceptCycle = cycleCount;
        e.tag         = tag;
        sbq.push_back(e);
    endtask

    // Present one request for a single cycle. Requests that are expected to
    // be ignored or abandoned are not tracked.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] expY, input int expLat,
                                 input bit track, input int tag);
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        if (track) begin
            pushExpected(expY, expLat, tag);
        end
    endtask

    // Wait, with a cycle bound, until the monitor has consumed every
    // expected result.
    task automatic waitDrain(input string what);
        int n;
        n = 0;
        while ((sbq.size() != 0) && (n < 60)) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (sbq.size() != 0) begin
            checkOutput({what, " drain timeout"}, W'(sbq.size()), '0);
            sbq.delete();
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge. Reset clears the
    // held-result model because the DUT forces Y to zero.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                lastY   = '0;
                busyRun = 0;
            end else begin
                #1;
                if (ready) begin
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected ready: actual Y=0x%h required no pulse", Y);
                    end else begin
                        cur     = sbq.pop_front();
                        measLat = cycleCount - cur.acceptCycle + 1;
                        checkOutput($sformatf("op%0d Y", cur.tag), Y, cur.y);
                        checkOutput($sformatf("op%0d latency", cur.tag), W'(measLat), W'(cur.lat));
                        checkOutput($sformatf("op%0d busy cycles", cur.tag), W'(busyRun), W'(cur.lat - 1));
                        lastY = cur.y;
                    end
                    busyRun = 0;
                end else begin
                    checkOutput("Y hold", Y, lastY);
                    if (busy) begin
                        busyRun++;
                    end else begin
                        busyRun = 0;
                    end
                end
            end
        end
    end

    // Directed sequence.
    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
`ifdef MULT_FP_RNE_EN
        rneExp = 32'h3FC00002;
`else
        rneExp = 32'h3FC00001;
`endif

        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset Y", Y, '0);
        checkOutput("reset busy", W'(busy), '0);
        checkOutput("reset ready", W'(ready), '0);
        rst_n = 1'b1;
        idleCycles(2);

        // Normal products, overflow, specials, flush and rounding.
        applyStimulus(32'h40C00000, 32'h40200000, 32'h41700000, NORM_LAT, 1'b1, 1);
        waitDrain("op1");
        applyStimulus(32'hC0000000, 32'h40400000, 32'hC0C00000, NORM_LAT, 1'b1, 2);
        waitDrain("op2");
        applyStimulus(32'h7F000000, 32'h40000000, 32'h7F800000, NORM_LAT, 1'b1, 3);
        waitDrain("op3");
        applyStimulus(32'h7F800000, 32'h00000000, 32'h7FC00000, SPEC_LAT, 1'b1, 4);
        waitDrain("op4");
        applyStimulus(32'h00400000, 32'h3F800000, 32'h00000000, SPEC_LAT, 1'b1, 5);
        waitDrain("op5");
        applyStimulus(32'h3F800001, 32'h3FC00000, rneExp, NORM_LAT, 1'b1, 6);
        waitDrain("op6");
        applyStimulus(32'h3F800000, 32'h3F800000, 32'h3F800000, NORM_LAT, 1'b1, 7);
        waitDrain("op7");
        applyStimulus(32'hFF800000, 32'h40000000, 32'hFF800000, SPEC_LAT, 1'b1, 8);
        waitDrain("op8");
        applyStimulus(32'h7F800001, 32'h3F800000, 32'h7FC00000, SPEC_LAT, 1'b1, 9);
        waitDrain("op9");
        applyStimulus(32'h80000000, 32'h40A00000, 32'h80000000, SPEC_LAT, 1'b1, 10);
        waitDrain("op10");
        applyStimulus(32'h00800000, 32'h00800000, 32'h00000000, NORM_LAT, 1'b1, 11);
        waitDrain("op11");

        // A start 10 cycles into an operation must be ignored.
        applyStimulus(32'h40C00000, 32'h40200000, 32'h41700000, NORM_LAT, 1'b1, 12);
        idleCycles(9);
        applyStimulus(32'h3F800000, 32'h40000000, '0, 0, 1'b0, 0);
        waitDrain("op12");
        idleCycles(40);
        checkOutput("ignored start busy", W'(busy), '0);

        // Start held high through the end of an operation is taken in DONE.
        applyStimulus(32'hC0000000, 32'h40400000, 32'hC0C00000, NORM_LAT, 1'b1, 13);
        idleCycles(20);
        A     = 32'h3FC00000;
        B     = 32'h3FC00000;
        start = 1'b1;
        n     = 0;
        while (!ready && (n < 40)) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput("b2b ready seen", W'(ready), W'(1));
        @(posedge clk);
        #2;
        start = 1'b0;
        checkOutput("b2b busy after DONE", W'(busy), W'(1));
        pushExpected(32'h40100000, NORM_LAT, 14);
        waitDrain("op14");

        // Reset in the middle of MULT abandons the operation.
        applyStimulus(32'h40000000, 32'h40400000, '0, 0, 1'b0, 0);
        idleCycles(5);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset Y", Y, '0);
        checkOutput("mid reset busy", W'(busy), '0);
        checkOutput("mid reset ready", W'(ready), '0);
        #2;
        rst_n = 1'b1;
        idleCycles(40);
        applyStimulus(32'h3FC00000, 32'h3FC00000, 32'h40100000, NORM_LAT, 1'b1, 15);
        waitDrain("op15");

        idleCycles(3);
        checkOutput("scoreboard empty", W'(sbq.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
